// File: rtl/amo_ocm_port.sv
// OCM port for a load/store/atomic pipeline: arbitrated single-master access, read-modify-write AMOs
// with bus lock, optional LR/SC reservation tracking enabled by defining AMO_LRSC_EN.
module amo_ocm_port #(
    parameter int DATA_W    = 32,
    parameter int ADDR_BITS = 12,
    parameter int BE_W      = DATA_W / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd,
    input  logic                 i_wr,
    input  logic                 i_is_atomic,
    input  logic [3:0]           i_atomic_op,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [BE_W-1:0]      i_dm_write,
    output logic                 o_req,
    input  logic                 i_grant,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic [DATA_W-1:0]    o_wdata,
    output logic [BE_W-1:0]      o_dm_write,
    input  logic [DATA_W-1:0]    i_rdata,
    input  logic                 i_rvalid,
    input  logic                 i_wvalid,
    output logic [DATA_W-1:0]    o_wb_data,
    output logic                 o_stall,
    output logic                 o_done
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_DONE} state_t;

    localparam logic [3:0] OP_SWAP = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_MIN  = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_MINU = 4'd8;
    localparam logic [3:0] OP_MAXU = 4'd9;
    localparam logic [3:0] OP_LR   = 4'd10;
    localparam logic [3:0] OP_SC   = 4'd11;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_temp;
    logic [DATA_W-1:0]   r_wb_data;
    logic [DATA_W-1:0]   w_result;
    logic [DATA_W-1:0]   w_wb_next;
    logic                w_wb_load;
    logic                w_req;
    logic                w_stall;
    logic                w_done;
    logic [BE_W-1:0]     w_dm_write;
    logic                w_any_req;
    logic                w_op_ok;
    logic                w_is_lr;
    logic                w_is_sc;
    logic                w_is_amo;
    logic                w_is_store;
    logic                w_sc_fail;
    logic                w_skip;

`ifdef AMO_LRSC_EN
    logic                 r_resv_valid;
    logic [ADDR_BITS-1:0] r_resv_addr;

    assign w_op_ok   = (i_atomic_op >= OP_SWAP) && (i_atomic_op <= OP_SC);
    assign w_sc_fail = w_is_sc && !(r_resv_valid && (r_resv_addr == i_addr));
`else
    assign w_op_ok   = (i_atomic_op >= OP_SWAP) && (i_atomic_op <= OP_MAXU);
    assign w_sc_fail = 1'b0;
`endif

    assign w_any_req  = i_rd | i_wr | i_is_atomic;
    assign w_is_lr    = i_is_atomic && w_op_ok && (i_atomic_op == OP_LR);
    assign w_is_sc    = i_is_atomic && w_op_ok && (i_atomic_op == OP_SC);
    assign w_is_amo   = i_is_atomic && w_op_ok && !w_is_lr && !w_is_sc;
    assign w_is_store = !i_is_atomic && i_wr;
    assign w_skip     = (i_is_atomic && !w_op_ok) || w_sc_fail;

    // Min/max ties keep the memory value, so the comparisons are strict.
    always_comb begin
        w_result = i_wdata;
        case (i_atomic_op)
            OP_SWAP: w_result = i_wdata;
            OP_ADD:  w_result = r_temp + i_wdata;
            OP_XOR:  w_result = r_temp ^ i_wdata;
            OP_AND:  w_result = r_temp & i_wdata;
            OP_OR:   w_result = r_temp | i_wdata;
            OP_MIN:  w_result = ($signed(i_wdata) < $signed(r_temp)) ? i_wdata : r_temp;
            OP_MAX:  w_result = ($signed(i_wdata) > $signed(r_temp)) ? i_wdata : r_temp;
            OP_MINU: w_result = (i_wdata < r_temp) ? i_wdata : r_temp;
            OP_MAXU: w_result = (i_wdata > r_temp) ? i_wdata : r_temp;
            default: w_result = i_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_next     = r_state;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_done     = 1'b0;
        w_dm_write = '0;
        o_wdata    = i_wdata;
        w_wb_load  = 1'b0;
        w_wb_next  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_stall = 1'b1;
                    w_next  = S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (!w_any_req) begin
                    w_next = S_IDLE;
                end else if (w_skip) begin
                    w_next    = S_DONE;
                    w_wb_load = 1'b1;
                    w_wb_next = w_sc_fail ? DATA_W'(1) : '0;
                end else begin
                    w_req = 1'b1;
                    if (i_grant) w_next = (w_is_store || w_is_sc) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                w_stall = 1'b1;
                w_req   = i_is_atomic;
                if (i_rvalid) begin
                    if (w_is_amo) begin
                        w_next = S_WR;
                    end else begin
                        w_next    = S_DONE;
                        w_wb_load = 1'b1;
                        w_wb_next = i_rdata;
                    end
                end
            end
            S_WR: begin
                w_stall    = 1'b1;
                w_req      = i_is_atomic;
                w_dm_write = i_is_atomic ? {BE_W{1'b1}} : i_dm_write;
                o_wdata    = w_is_amo ? w_result : i_wdata;
                if (i_wvalid) begin
                    w_next    = S_DONE;
                    w_wb_load = 1'b1;
                    w_wb_next = w_is_amo ? r_temp : '0;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request-driven stall is combinational from the inputs, so reset must mask it explicitly.
    assign o_req      = w_req & ~rst;
    assign o_stall    = w_stall & ~rst;
    assign o_done     = w_done & ~rst;
    assign o_dm_write = rst ? '0 : w_dm_write;
    assign o_addr     = i_addr;
    assign o_wb_data  = r_wb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_temp    <= '0;
            r_wb_data <= '0;
        end else begin
            if (r_state == S_RD && i_rvalid) r_temp <= i_rdata;
            if (w_wb_load)                    r_wb_data <= w_wb_next;
        end
    end

`ifdef AMO_LRSC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
        end else if (r_state == S_RD && i_rvalid && w_is_lr) begin
            r_resv_valid <= 1'b1;
            r_resv_addr  <= i_addr;
        end else if (r_state == S_REQ && w_any_req && w_sc_fail) begin
            r_resv_valid <= 1'b0;
        end else if (r_state == S_WR && i_wvalid &&
                     (w_is_sc || (r_resv_valid && r_resv_addr == i_addr))) begin
            r_resv_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_amo_ocm_port.sv
// Directed self-checking bench for amo_ocm_port; exercises LR/SC when AMO_LRSC_EN is defined,
// otherwise checks that ops 10/11 are treated as unsupported.
module tb_amo_ocm_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd = 1'b0, i_wr = 1'b0, i_is_atomic = 1'b0;
    logic [3:0]  i_atomic_op = 4'd0;
    logic [11:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_dm_write = '0;
    logic        o_req;
    logic        i_grant = 1'b1;
    logic [11:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_dm_write;
    logic [31:0] i_rdata = '0;
    logic        i_rvalid = 1'b1;
    logic        i_wvalid = 1'b1;
    logic [31:0] o_wb_data;
    logic        o_stall;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    int          wr_tot = 0, req_tot = 0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;
    int          wr_base, req_base;

    amo_ocm_port dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_wr(i_wr), .i_is_atomic(i_is_atomic), .i_atomic_op(i_atomic_op),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_dm_write(i_dm_write),
        .o_req(o_req), .i_grant(i_grant),
        .o_addr(o_addr), .o_wdata(o_wdata), .o_dm_write(o_dm_write),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_wvalid(i_wvalid),
        .o_wb_data(o_wb_data), .o_stall(o_stall), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Bus monitor: counts request cycles and write beats, remembers the last write.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_req) req_tot++;
            if (o_dm_write != 4'h0) begin
                wr_tot++;
                last_wdata = o_wdata;
                last_be    = o_dm_write;
            end
        end
    end

    // Launch one request right after a rising edge (cycle 0) and wait for o_done.
    // cyc is the cycle index of o_done, or 99 if it never came.
    task automatic do_op(input logic rd, input logic wr, input logic at, input logic [3:0] op,
                         input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] be,
                         output int cyc, output logic stall0);
        @(posedge clk);
        #1;
        wr_base = wr_tot;
        req_base = req_tot;
        i_rd = rd; i_wr = wr; i_is_atomic = at; i_atomic_op = op;
        i_addr = addr; i_wdata = wd; i_dm_write = be;
        @(negedge clk);
        stall0 = o_stall;
        cyc = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (o_done) begin
                cyc = n;
                break;
            end
        end
        i_rd = 1'b0; i_wr = 1'b0; i_is_atomic = 1'b0;
    endtask

    task automatic test_reset();
        i_rd = 1'b1;
        #12;
        checks++;
        if ({o_req, o_stall, o_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/stall/done=%b want 000", {o_req, o_stall, o_done});
        end
        checks++;
        if (o_dm_write !== 4'h0 || o_wb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got be=%h wb=%h want be=0 wb=0", o_dm_write, o_wb_data);
        end
        i_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got stall=%b req=%b want 0 0", o_stall, o_req);
        end
    endtask

    task automatic test_amo_ops();
        logic [3:0]  ops [14] = '{4'd2, 4'd2, 4'd6, 4'd8, 4'd7, 4'd9, 4'd1,
                                  4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd7, 4'd9};
        logic [31:0] mems[14] = '{32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                  32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1234, 32'hF5, 32'hF5,
                                  32'hF5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'h7FFF_FFFF};
        logic [31:0] rs2s[14] = '{32'h3, 32'h2, 32'h1, 32'h1, 32'h1, 32'h1, 32'hCAFE,
                                  32'h0F, 32'h0F, 32'h0F, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                  32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exps[14] = '{32'h8, 32'h1, 32'hFFFF_FFFE, 32'h1, 32'h1, 32'hFFFF_FFFE,
                                  32'hCAFE, 32'hFA, 32'h05, 32'hFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        int   cyc;
        logic st0;
        for (int k = 0; k < 14; k++) begin
            i_rdata = mems[k];
            do_op(1'b0, 1'b0, 1'b1, ops[k], 12'h040, rs2s[k], 4'h0, cyc, st0);
            checks++;
            if (cyc !== 4 || st0 !== 1'b1) begin
                errors++;
                $display("FAIL amo%0d_latency: got cyc=%0d stall0=%b want cyc=4 stall0=1", k, cyc, st0);
            end
            checks++;
            if (wr_tot - wr_base !== 1 || last_be !== 4'hF || last_wdata !== exps[k]) begin
                errors++;
                $display("FAIL amo%0d_write: got n=%0d be=%h data=%h want n=1 be=f data=%h",
                         k, wr_tot - wr_base, last_be, last_wdata, exps[k]);
            end
            checks++;
            if (o_wb_data !== mems[k]) begin
                errors++;
                $display("FAIL amo%0d_wb: got %h want %h", k, o_wb_data, mems[k]);
            end
            if (k == 0) begin
                checks++;
                if (o_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL done_stall: got %b want 0", o_stall);
                end
                @(negedge clk);
                checks++;
                if (o_done !== 1'b0 || o_wb_data !== 32'h5) begin
                    errors++;
                    $display("FAIL done_pulse: got done=%b wb=%h want done=0 wb=5", o_done, o_wb_data);
                end
            end
        end
    endtask

    task automatic test_load_store();
        int   cyc;
        logic st0;
        i_rdata = 32'h5A5A_0001;
        do_op(1'b1, 1'b0, 1'b0, 4'd0, 12'h020, 32'h0, 4'h0, cyc, st0);
        checks++;
        if (cyc !== 3 || wr_tot - wr_base !== 0 || o_wb_data !== 32'h5A5A_0001) begin
            errors++;
            $display("FAIL load: got cyc=%0d writes=%0d wb=%h want 3 0 5a5a0001",
                     cyc, wr_tot - wr_base, o_wb_data);
        end
        do_op(1'b0, 1'b1, 1'b0, 4'd0, 12'h030, 32'hDEAD_BEEF, 4'b0011, cyc, st0);
        checks++;
        if (cyc !== 3 || wr_tot - wr_base !== 1 || last_be !== 4'b0011 || last_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store: got cyc=%0d n=%0d be=%h data=%h want 3 1 3 deadbeef",
                     cyc, wr_tot - wr_base, last_be, last_wdata);
        end
    endtask

    task automatic test_grant_wait();
        int   cyc;
        logic bad;
        @(posedge clk);
        #1;
        wr_base = wr_tot;
        req_base = req_tot;
        i_rdata = 32'h0BAD_F00D;
        i_grant = 1'b0;
        i_rd = 1'b1; i_addr = 12'h050;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall0: got %b want 1", o_stall);
        end
        bad = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (o_req !== 1'b1 || o_stall !== 1'b1 || o_dm_write !== 4'h0 || o_done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: got bad=%b want 0", bad);
        end
        @(posedge clk);
        #1;
        i_grant = 1'b1;
        cyc = 99;
        for (int n = 6; n <= 20; n++) begin
            @(negedge clk);
            if (o_done) begin
                cyc = n;
                break;
            end
        end
        i_rd = 1'b0;
        checks++;
        if (cyc !== 8 || req_tot - req_base !== 6 || o_wb_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wait_done: got cyc=%0d req_cycles=%0d wb=%h want 8 6 0badf00d",
                     cyc, req_tot - req_base, o_wb_data);
        end
    endtask

    task automatic test_drop();
        logic seen_done;
        @(posedge clk);
        #1;
        wr_base = wr_tot;
        i_grant = 1'b0;
        i_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_req !== 1'b1) begin
            errors++;
            $display("FAIL drop_req: got %b want 1", o_req);
        end
        i_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got stall=%b req=%b want 0 0", o_stall, o_req);
        end
        seen_done = o_done;
        repeat (3) begin
            @(negedge clk);
            seen_done = seen_done | o_done;
        end
        checks++;
        if (seen_done !== 1'b0 || wr_tot - wr_base !== 0) begin
            errors++;
            $display("FAIL drop_noaccess: got done=%b writes=%0d want 0 0", seen_done, wr_tot - wr_base);
        end
        i_grant = 1'b1;
    endtask

    task automatic test_unsupported();
        int   cyc;
        logic st0;
        logic [3:0] bad_ops[3] = '{4'd0, 4'd12, 4'd15};
        for (int k = 0; k < 3; k++) begin
            i_rdata = 32'h7777_0000 + k;
            do_op(1'b1, 1'b0, 1'b0, 4'd0, 12'h060, 32'h0, 4'h0, cyc, st0);
            do_op(1'b0, 1'b0, 1'b1, bad_ops[k], 12'h060, 32'h1, 4'h0, cyc, st0);
            checks++;
            if (cyc !== 2 || req_tot - req_base !== 0 || wr_tot - wr_base !== 0 || o_wb_data !== 32'h0) begin
                errors++;
                $display("FAIL unsup_op%0d: got cyc=%0d req=%0d wr=%0d wb=%h want 2 0 0 0",
                         bad_ops[k], cyc, req_tot - req_base, wr_tot - wr_base, o_wb_data);
            end
        end
    endtask

    task automatic test_lrsc();
        int   cyc;
        logic st0;
`ifdef AMO_LRSC_EN
        i_rdata = 32'h0000_00AB;
        do_op(1'b0, 1'b0, 1'b1, 4'd10, 12'h010, 32'h0, 4'h0, cyc, st0);
        checks++;
        if (cyc !== 3 || wr_tot - wr_base !== 0 || o_wb_data !== 32'hAB) begin
            errors++;
            $display("FAIL lr: got cyc=%0d wr=%0d wb=%h want 3 0 ab", cyc, wr_tot - wr_base, o_wb_data);
        end
        do_op(1'b0, 1'b0, 1'b1, 4'd11, 12'h010, 32'h55, 4'h0, cyc, st0);
        checks++;
        if (cyc !== 3 || wr_tot - wr_base !== 1 || last_be !== 4'hF || last_wdata !== 32'h55 || o_wb_data !== 32'h0) begin
            errors++;
            $display("FAIL sc_ok: got cyc=%0d n=%0d be=%h data=%h wb=%h want 3 1 f 55 0",
                     cyc, wr_tot - wr_base, last_be, last_wdata, o_wb_data);
        end
        do_op(1'b0, 1'b0, 1'b1, 4'd11, 12'h010, 32'h66, 4'h0, cyc, st0);
        checks++;
        if (cyc !== 2 || req_tot - req_base !== 0 || wr_tot - wr_base !== 0 || o_wb_data !== 32'h1) begin
            errors++;
            $display("FAIL sc_repeat: got cyc=%0d req=%0d wr=%0d wb=%h want 2 0 0 1",
                     cyc, req_tot - req_base, wr_tot - wr_base, o_wb_data);
        end
        do_op(1'b0, 1'b0, 1'b1, 4'd10, 12'h020, 32'h0, 4'h0, cyc, st0);
        do_op(1'b0, 1'b1, 1'b0, 4'd0, 12'h020, 32'h9, 4'hF, cyc, st0);
        do_op(1'b0, 1'b0, 1'b1, 4'd11, 12'h020, 32'h77, 4'h0, cyc, st0);
        checks++;
        if (cyc !== 2 || req_tot - req_base !== 0 || o_wb_data !== 32'h1) begin
            errors++;
            $display("FAIL sc_after_store: got cyc=%0d req=%0d wb=%h want 2 0 1",
                     cyc, req_tot - req_base, o_wb_data);
        end
`else
        for (int op = 10; op <= 11; op++) begin
            i_rdata = 32'h1357_0000 + op;
            do_op(1'b1, 1'b0, 1'b0, 4'd0, 12'h010, 32'h0, 4'h0, cyc, st0);
            do_op(1'b0, 1'b0, 1'b1, 4'(op), 12'h010, 32'h55, 4'h0, cyc, st0);
            checks++;
            if (cyc !== 2 || req_tot - req_base !== 0 || wr_tot - wr_base !== 0 || o_wb_data !== 32'h0) begin
                errors++;
                $display("FAIL lrsc_off_op%0d: got cyc=%0d req=%0d wr=%0d wb=%h want 2 0 0 0",
                         op, cyc, req_tot - req_base, wr_tot - wr_base, o_wb_data);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        int   cyc;
        logic st0;
        i_rdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        i_wvalid = 1'b0;
        i_is_atomic = 1'b1; i_atomic_op = 4'd1; i_addr = 12'h070; i_wdata = 32'hCAFE;
        repeat (4) @(negedge clk);
        checks++;
        if (o_dm_write !== 4'hF || o_req !== 1'b1 || o_wdata !== 32'hCAFE) begin
            errors++;
            $display("FAIL stuck_wr: got be=%h req=%b data=%h want f 1 cafe", o_dm_write, o_req, o_wdata);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_req, o_stall, o_done} !== 3'b000 || o_dm_write !== 4'h0 || o_wb_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got req/stall/done=%b be=%h wb=%h want 000 0 0",
                     {o_req, o_stall, o_done}, o_dm_write, o_wb_data);
        end
        i_is_atomic = 1'b0;
        i_wvalid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_base = wr_tot;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_tot - wr_base !== 0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_retry: got writes=%0d stall=%b want 0 0", wr_tot - wr_base, o_stall);
        end
        do_op(1'b0, 1'b0, 1'b1, 4'd1, 12'h070, 32'hCAFE, 4'h0, cyc, st0);
        checks++;
        if (cyc !== 4 || last_wdata !== 32'hCAFE || wr_tot - wr_base !== 1 || o_wb_data !== 32'h1234) begin
            errors++;
            $display("FAIL swap_after_reset: got cyc=%0d data=%h n=%0d wb=%h want 4 cafe 1 1234",
                     cyc, last_wdata, wr_tot - wr_base, o_wb_data);
        end
    endtask

    initial begin
        test_reset();
        test_amo_ops();
        test_load_store();
        test_grant_wait();
        test_drop();
        test_unsupported();
        test_lrsc();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
